// File: rtl/baser_257b_decoder_pkg.sv
// Shared constants, FSM state type and control-type reconstruction for the
// BASE-R 257b -> 4x66b reverse transcoder.
package baser_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned HDR_W     = 2;
    localparam int unsigned FRAME_W   = DATA_W + HDR_W;
    localparam int unsigned XC_BLOCKS = 4;
    localparam int unsigned XC_W      = 257;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;
    localparam logic [1:0] SH_ERR  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] type_byte;
    } ctrl_type_t;

    // Only the high nibble of the first control block's type byte is carried.
    function automatic ctrl_type_t nibble_to_type(input logic [3:0] nib);
        ctrl_type_t r;
        r.valid = 1'b1;
        case (nib)
            4'h1:    r.type_byte = 8'h1E;
            4'h2:    r.type_byte = 8'h2D;
            4'h3:    r.type_byte = 8'h33;
            4'h4:    r.type_byte = 8'h4B;
            4'h5:    r.type_byte = 8'h55;
            4'h6:    r.type_byte = 8'h66;
            4'h7:    r.type_byte = 8'h78;
            4'h8:    r.type_byte = 8'h87;
            4'h9:    r.type_byte = 8'h99;
            4'hA:    r.type_byte = 8'hAA;
            4'hB:    r.type_byte = 8'hB4;
            4'hC:    r.type_byte = 8'hCC;
            4'hD:    r.type_byte = 8'hD2;
            4'hE:    r.type_byte = 8'hE1;
            4'hF:    r.type_byte = 8'hFF;
            default: begin
                r.valid     = 1'b0;
                r.type_byte = 8'h00;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/baser_257b_decoder_unpack.sv
// Combinational split of one 257b transcoded block into four 66b blocks.
module baser_257b_unpack
    import baser_pkg::*;
(
    input  logic [XC_W-1:0]            coded_i,
    output logic [XC_BLOCKS*FRAME_W-1:0] frames_o,
    output logic                       invalid_o
);

    // Zero padding keeps every variable-offset select in range.
    logic [XC_W+7:0] ext;
    ctrl_type_t      ct;
    int unsigned     off;
    logic            first_seen;

    assign ext = {8'h00, coded_i};
    assign ct  = nibble_to_type(coded_i[8:5]);

    always_comb begin
        frames_o   = '0;
        invalid_o  = 1'b0;
        off        = 9;
        first_seen = 1'b0;
        if (coded_i[0]) begin
            for (int unsigned j = 0; j < XC_BLOCKS; j++) begin
                frames_o[j*FRAME_W +: FRAME_W] = {SH_DATA, coded_i[1 + DATA_W*j +: DATA_W]};
            end
        end else if (coded_i[4:1] == 4'hF || !ct.valid) begin
            invalid_o = 1'b1;
            for (int unsigned j = 0; j < XC_BLOCKS; j++) begin
                frames_o[j*FRAME_W +: FRAME_W] = {SH_ERR, {DATA_W{1'b0}}};
            end
        end else begin
            // The first control block drops its type byte, shifting later blocks down by 8.
            for (int unsigned j = 0; j < XC_BLOCKS; j++) begin
                if (coded_i[1 + j]) begin
                    frames_o[j*FRAME_W +: FRAME_W] = {SH_DATA, ext[off +: 64]};
                    off = off + 64;
                end else if (!first_seen) begin
                    frames_o[j*FRAME_W +: FRAME_W] = {SH_CTRL, ext[off +: 56], ct.type_byte};
                    off        = off + 56;
                    first_seen = 1'b1;
                end else begin
                    frames_o[j*FRAME_W +: FRAME_W] = {SH_CTRL, ext[off +: 64]};
                    off = off + 64;
                end
            end
        end
    end

endmodule

// File: rtl/baser_257b_decoder.sv
// BASE-R receive reverse transcoder: one 257b block in, four 66b blocks out
// with valid/ready flow control and saturating block/error counters.
module baser_257b_decoder
    import baser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned HDR_WIDTH         = 2,
    parameter int unsigned FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH,
    parameter int unsigned TRANSCODER_BLOCKS = 4,
    parameter int unsigned TRANSCODER_WIDTH  = 257
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic [TRANSCODER_WIDTH-1:0] i_rx_coded,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [FRAME_WIDTH-1:0]      o_frame,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [31:0]                 o_block_count,
    output logic [31:0]                 o_inv_block_count
);

    localparam logic [1:0] IDX_LAST = 2'(TRANSCODER_BLOCKS - 1);

    state_e                                  state_q, state_d;
    logic [1:0]                              idx_q, idx_d;
    logic [TRANSCODER_BLOCKS*FRAME_WIDTH-1:0] frames_q;
    logic [XC_BLOCKS*FRAME_W-1:0]            frames_dec;
    logic                                    invalid_dec;
    logic [31:0]                             blk_cnt_q, inv_cnt_q;
    logic                                    accept;

    baser_257b_unpack u_unpack (
        .coded_i   (i_rx_coded),
        .frames_o  (frames_dec),
        .invalid_o (invalid_dec)
    );

    assign o_ready = i_rst_n && ((state_q == ST_IDLE) || (idx_q == IDX_LAST && i_ready));
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                end
            end
            ST_EMIT: begin
                if (i_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = i_valid ? ST_EMIT : ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_valid = (state_q == ST_EMIT);
        o_frame = '0;
        if (state_q == ST_EMIT) begin
            o_frame = frames_q[idx_q*FRAME_WIDTH +: FRAME_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frames_q  <= '0;
            blk_cnt_q <= '0;
            inv_cnt_q <= '0;
        end else if (accept) begin
            frames_q <= frames_dec;
            if (blk_cnt_q != '1) begin
                blk_cnt_q <= blk_cnt_q + 32'd1;
            end
            if (invalid_dec && inv_cnt_q != '1) begin
                inv_cnt_q <= inv_cnt_q + 32'd1;
            end
        end
    end

    assign o_block_count     = blk_cnt_q;
    assign o_inv_block_count = inv_cnt_q;

endmodule

// File: tb/tb_baser_257b_decoder.sv
// Directed self-checking bench for baser_257b_decoder; inputs driven and
// outputs sampled on the falling clock edge.
module tb_baser_257b_decoder;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic [256:0] i_rx_coded;
    logic         i_valid;
    logic         o_ready;
    logic [65:0]  o_frame;
    logic         o_valid;
    logic         i_ready;
    logic [31:0]  o_block_count;
    logic [31:0]  o_inv_block_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_blk  = 0;
    int unsigned exp_inv  = 0;

    always #5 clk = ~clk;

    baser_257b_decoder #(
        .DATA_WIDTH        (64),
        .HDR_WIDTH         (2),
        .FRAME_WIDTH       (66),
        .TRANSCODER_BLOCKS (4),
        .TRANSCODER_WIDTH  (257)
    ) dut (
        .clk               (clk),
        .i_rst_n           (i_rst_n),
        .i_rx_coded        (i_rx_coded),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .o_frame           (o_frame),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_block_count     (o_block_count),
        .o_inv_block_count (o_inv_block_count)
    );

    task automatic check_eq(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) check_eq("ready_timeout", 66'(o_ready), 66'd1);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_blk"}, 66'(o_block_count), 66'(exp_blk));
        check_eq({tag, "_inv"}, 66'(o_inv_block_count), 66'(exp_inv));
    endtask

    task automatic send_block(input string name, input logic [256:0] b, input logic inv,
                              input logic [65:0] e0, input logic [65:0] e1,
                              input logic [65:0] e2, input logic [65:0] e3);
        logic [65:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        @(negedge clk);
        i_rx_coded = b;
        i_valid    = 1'b1;
        wait_ready();
        @(negedge clk);
        i_valid = 1'b0;
        exp_blk++;
        if (inv) exp_inv++;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check_eq($sformatf("%s_v%0d", name, k), 66'(o_valid), 66'd1);
            check_eq($sformatf("%s_f%0d", name, k), o_frame, e[k]);
        end
        @(negedge clk);
        check_eq({name, "_idle"}, 66'(o_valid), 66'd0);
        check_counts(name);
    endtask

    logic [256:0] b_data, b_idle, b_mix, b_inv, b_nib0;
    logic [65:0]  err_f;

    initial begin
        i_rst_n    = 1'b0;
        i_rx_coded = '0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        err_f      = {2'b11, 64'h0};

        b_data = {{32{8'hAA}}, 1'b1};
        b_idle = '0;
        b_idle[8:5] = 4'h1;
        b_mix  = '0;
        b_mix[4:1]     = 4'b0101;
        b_mix[8:5]     = 4'h7;
        b_mix[72:9]    = 64'h0123456789ABCDEF;
        b_mix[128:73]  = 56'h11223344556677;
        b_mix[192:129] = 64'hDEADBEEFCAFEF00D;
        b_mix[256:193] = 64'hA5A5A5A5A5A5A52D;
        b_inv  = {248'h5A5A, 4'h3, 4'b1111, 1'b0};
        b_nib0 = {248'h1234, 4'h0, 4'b0000, 1'b0};

        repeat (2) @(negedge clk);
        check_eq("rst_ready", 66'(o_ready), 66'd0);
        check_eq("rst_valid", 66'(o_valid), 66'd0);
        check_eq("rst_frame", o_frame, 66'd0);
        check_counts("rst");
        i_rst_n = 1'b1;
        #1;
        check_eq("rel_ready", 66'(o_ready), 66'd1);

        send_block("data", b_data, 1'b0, {2'b01, {8{8'hAA}}}, {2'b01, {8{8'hAA}}},
                   {2'b01, {8{8'hAA}}}, {2'b01, {8{8'hAA}}});
        send_block("idle", b_idle, 1'b0, {2'b10, 64'h1E}, {2'b10, 64'h0},
                   {2'b10, 64'h0}, {2'b10, 64'h0});
        send_block("inv", b_inv, 1'b1, err_f, err_f, err_f, err_f);
        send_block("nib0", b_nib0, 1'b1, err_f, err_f, err_f, err_f);

        // Mixed block with a 3-cycle stall at idx 1 while a new block is offered.
        @(negedge clk);
        i_rx_coded = b_mix;
        i_valid    = 1'b1;
        wait_ready();
        @(negedge clk);
        i_valid = 1'b0;
        exp_blk++;
        check_eq("mix_f0", o_frame, {2'b01, 64'h0123456789ABCDEF});
        @(negedge clk);
        check_eq("mix_f1", o_frame, {2'b10, 56'h11223344556677, 8'h78});
        i_ready    = 1'b0;
        i_valid    = 1'b1;
        i_rx_coded = b_data;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_f%0d", k), o_frame, {2'b10, 56'h11223344556677, 8'h78});
            check_eq($sformatf("bp_v%0d", k), 66'(o_valid), 66'd1);
            check_eq($sformatf("bp_rdy%0d", k), 66'(o_ready), 66'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check_eq("mix_f2", o_frame, {2'b01, 64'hDEADBEEFCAFEF00D});
        @(negedge clk);
        check_eq("mix_f3", o_frame, {2'b10, 64'hA5A5A5A5A5A5A52D});
        @(negedge clk);
        check_eq("mix_idle", 66'(o_valid), 66'd0);
        check_counts("mix");

        // Back-to-back: data block then idle block, eight frames with no bubble.
        @(negedge clk);
        i_rx_coded = b_data;
        i_valid    = 1'b1;
        wait_ready();
        @(negedge clk);
        i_rx_coded = b_idle;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) i_valid = 1'b0;
            check_eq($sformatf("b2b_v%0d", k), 66'(o_valid), 66'd1);
            if (k < 4) check_eq($sformatf("b2b_f%0d", k), o_frame, {2'b01, {8{8'hAA}}});
            else if (k == 4) check_eq("b2b_f4", o_frame, {2'b10, 64'h1E});
            else check_eq($sformatf("b2b_f%0d", k), o_frame, {2'b10, 64'h0});
            if (k == 1) check_eq("b2b_rdy_idx1", 66'(o_ready), 66'd0);
        end
        exp_blk += 2;
        @(negedge clk);
        check_eq("b2b_idle", 66'(o_valid), 66'd0);
        check_counts("b2b");

        // Reset while the third frame is on the output.
        @(negedge clk);
        i_rx_coded = b_mix;
        i_valid    = 1'b1;
        wait_ready();
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_f2", o_frame, {2'b01, 64'hDEADBEEFCAFEF00D});
        i_rst_n = 1'b0;
        #1;
        exp_blk = 0;
        exp_inv = 0;
        check_eq("mid_rst_valid", 66'(o_valid), 66'd0);
        check_eq("mid_rst_ready", 66'(o_ready), 66'd0);
        check_counts("mid_rst");
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        check_eq("mid_rel_ready", 66'(o_ready), 66'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_v%0d", k), 66'(o_valid), 66'd0);
        end
        check_counts("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
